// File: rtl/l_func_pkg.sv
// Shared types and defaults for the Paillier L-function exact divider.
package l_func_pkg;

  localparam int K_DEF       = 128;
  localparam int N_DEF       = 32;
  localparam int MUL_LAT_DEF = 2;

  typedef logic [K_DEF-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_QCALC,
    ST_MULSUB,
    ST_CHECK,
    ST_DONE
  } l_state_e;

endpackage

// File: rtl/l_func_mul_word.sv
// Pipelined KxK->2K multiplier; operands are captured every cycle, the valid
// bit tracks which products belong to issued operations.
module l_func_mul_word #(
  parameter int K       = 128,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [K-1:0]   op_a,
  input  logic [K-1:0]   op_b,
  output logic           out_valid,
  output logic [2*K-1:0] prod
);

  logic [2*K-1:0]     prod_reg [MUL_LAT];
  logic [MUL_LAT-1:0] vld_reg;

  always_ff @(posedge clk) begin
    prod_reg[0] <= {{K{1'b0}}, op_a} * {{K{1'b0}}, op_b};
    for (int s = 1; s < MUL_LAT; s++) begin
      prod_reg[s] <= prod_reg[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= in_valid;
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_reg[s] <= vld_reg[s-1];
      end
    end
  end

  assign out_valid = vld_reg[MUL_LAT-1];
  assign prod      = prod_reg[MUL_LAT-1];

endmodule

// File: rtl/l_func_exact_div.sv
// L(x) = (x-1)/n by word-serial exact division, least significant word first.
// Quotient words stream out as they are found; a nonzero high residue flags L_err.
module l_func_exact_div
  import l_func_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int N       = N_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] n_word,
  input  logic         n_valid,
  input  logic [K-1:0] n_inv0,
  input  logic         task_start,
  input  logic [K-1:0] L_x,
  input  logic         L_x_valid,
  output logic [K-1:0] L_out,
  output logic         L_out_valid,
  output logic         L_done,
  output logic         L_err,
  output logic         busy
);

  localparam int AW = $clog2(2*N);
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2*N + MUL_LAT + 2) + 1;

  localparam logic [CW-1:0] NX  = CW'(N);
  localparam logic [CW-1:0] NX2 = CW'(2*N);
  localparam logic [CW-1:0] ML  = CW'(MUL_LAT);

  l_state_e       state_reg, state_next;
  logic [CW-1:0]  i_reg, i_next;
  logic [CW-1:0]  k_reg, k_next;
  logic [CW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic           ld_borrow_reg, ld_borrow_next;
  logic           b_reg, b_next;
  logic [K-1:0]   c_reg, c_next;
  logic [K-1:0]   q_reg, q_next;
  logic           err_reg, err_next;
  logic [K-1:0]   n_inv0_reg, n_inv0_next;
  logic [NW-1:0]  n_widx_reg, n_widx_next;

  logic [K-1:0]   a_mem [2*N];
  logic [K-1:0]   n_mem [N];
  logic [K-1:0]   a_rd_reg;
  logic [K-1:0]   n_rd_reg;
  logic           n_zero_reg;

  logic           a_we;
  logic [AW-1:0]  a_waddr;
  logic [K-1:0]   a_wdata;
  logic [AW-1:0]  a_raddr;
  logic [CW-1:0]  n_raddr;
  logic           n_we;

  logic           mul_in_valid;
  logic [K-1:0]   mul_a, mul_b;
  logic           mul_out_valid;
  logic [2*K-1:0] mul_prod;

  logic [CW-1:0]  ms_last, issue_max;
  logic [2*K-1:0] t;
  logic [K:0]     diff;

  logic           l_out_valid_c;
  logic           l_done_c;

  l_func_mul_word #(.K(K), .MUL_LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mul_in_valid),
    .op_a      (mul_a),
    .op_b      (mul_b),
    .out_valid (mul_out_valid),
    .prod      (mul_prod)
  );

  assign ms_last   = NX2 - i_reg + ML;
  assign issue_max = NX2 - 1'b1 - i_reg;

  // Read addresses run one cycle ahead of use because both arrays read registered.
  always_comb begin
    state_next     = state_reg;
    i_next         = i_reg;
    k_next         = k_reg;
    wr_ptr_next    = wr_ptr_reg;
    ld_borrow_next = ld_borrow_reg;
    b_next         = b_reg;
    c_next         = c_reg;
    q_next         = q_reg;
    err_next       = err_reg;
    n_inv0_next    = n_inv0_reg;
    n_widx_next    = n_widx_reg;
    a_we           = 1'b0;
    a_waddr        = wr_ptr_reg[AW-1:0];
    a_wdata        = '0;
    a_raddr        = AW'(i_reg);
    n_raddr        = '0;
    n_we           = 1'b0;
    mul_in_valid   = 1'b0;
    mul_a          = q_reg;
    mul_b          = n_zero_reg ? '0 : n_rd_reg;
    t              = '0;
    diff           = '0;
    l_out_valid_c  = 1'b0;
    l_done_c       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (n_valid) begin
          n_we        = 1'b1;
          n_widx_next = (n_widx_reg == NW'(N-1)) ? '0 : n_widx_reg + 1'b1;
        end
        if (task_start) begin
          state_next     = ST_LOAD;
          wr_ptr_next    = '0;
          i_next         = '0;
          ld_borrow_next = 1'b1;
          err_next       = 1'b0;
          n_inv0_next    = n_inv0;
        end
      end
      ST_LOAD: begin
        if (L_x_valid) begin
          a_we           = 1'b1;
          a_wdata        = L_x - {{(K-1){1'b0}}, ld_borrow_reg};
          ld_borrow_next = ld_borrow_reg & (L_x == '0);
          wr_ptr_next    = wr_ptr_reg + 1'b1;
          if (wr_ptr_reg == NX2 - 1'b1) begin
            state_next = ST_QCALC;
            k_next     = '0;
          end
        end
      end
      ST_QCALC: begin
        mul_a        = a_rd_reg;
        mul_b        = n_inv0_reg;
        mul_in_valid = (k_reg == '0);
        k_next       = k_reg + 1'b1;
        if (k_reg == ML) begin
          l_out_valid_c = 1'b1;
          q_next        = mul_prod[K-1:0];
          state_next    = ST_MULSUB;
          k_next        = '0;
          wr_ptr_next   = i_reg;
          b_next        = 1'b0;
          c_next        = '0;
        end
      end
      ST_MULSUB: begin
        mul_in_valid = (k_reg <= issue_max);
        n_raddr      = k_reg + 1'b1;
        a_raddr      = (k_reg == ms_last) ? AW'(i_reg + 1'b1)
                                          : AW'(k_reg + i_reg + 1'b1 - ML);
        if (mul_out_valid) begin
          t           = mul_prod + {{K{1'b0}}, c_reg};
          diff        = {1'b0, a_rd_reg} - {1'b0, t[K-1:0]} - {{K{1'b0}}, b_reg};
          a_we        = 1'b1;
          a_wdata     = diff[K-1:0];
          b_next      = diff[K];
          c_next      = t[2*K-1:K];
          wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        k_next = k_reg + 1'b1;
        if (k_reg == ms_last) begin
          k_next = '0;
          if (i_reg == NX - 1'b1) begin
            state_next = ST_CHECK;
          end else begin
            i_next     = i_reg + 1'b1;
            state_next = ST_QCALC;
          end
        end
      end
      ST_CHECK: begin
        a_raddr  = AW'(NX + k_reg + 1'b1);
        err_next = err_reg | (|a_rd_reg);
        k_next   = k_reg + 1'b1;
        if (k_reg == NX - 1'b1) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        l_done_c   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      i_reg         <= '0;
      k_reg         <= '0;
      wr_ptr_reg    <= '0;
      ld_borrow_reg <= 1'b0;
      b_reg         <= 1'b0;
      c_reg         <= '0;
      q_reg         <= '0;
      err_reg       <= 1'b0;
      n_inv0_reg    <= '0;
      n_widx_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      i_reg         <= i_next;
      k_reg         <= k_next;
      wr_ptr_reg    <= wr_ptr_next;
      ld_borrow_reg <= ld_borrow_next;
      b_reg         <= b_next;
      c_reg         <= c_next;
      q_reg         <= q_next;
      err_reg       <= err_next;
      n_inv0_reg    <= n_inv0_next;
      n_widx_reg    <= n_widx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (a_we) begin
      a_mem[a_waddr] <= a_wdata;
    end
    a_rd_reg <= a_mem[a_raddr];
  end

  // Words at or beyond N read as zero so the subtract runs across the full 2N span.
  always_ff @(posedge clk) begin
    if (n_we) begin
      n_mem[n_widx_reg] <= n_word;
    end
    n_rd_reg   <= n_mem[n_raddr[NW-1:0]];
    n_zero_reg <= (n_raddr >= NX);
  end

  assign L_out_valid = l_out_valid_c;
  assign L_out       = l_out_valid_c ? mul_prod[K-1:0] : '0;
  assign L_done      = l_done_c;
  assign L_err       = l_done_c & err_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_l_func_exact_div.sv
// Directed bench for the L-function divider at K=8, N=2, MUL_LAT=2.
module tb_l_func_exact_div;

  localparam int K   = 8;
  localparam int N   = 2;
  localparam int ML  = 2;
  localparam int LAT = 2*N + 1 + N*(2*N + 2*ML + 2) - N*(N-1)/2 + N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [K-1:0] n_word = '0;
  logic         n_valid = 1'b0;
  logic [K-1:0] n_inv0 = 8'h01;
  logic         task_start = 1'b0;
  logic [K-1:0] L_x = '0;
  logic         L_x_valid = 1'b0;
  logic [K-1:0] L_out;
  logic         L_out_valid;
  logic         L_done;
  logic         L_err;
  logic         busy;

  always #5 clk = ~clk;

  l_func_exact_div #(.K(K), .N(N), .MUL_LAT(ML)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .n_word      (n_word),
    .n_valid     (n_valid),
    .n_inv0      (n_inv0),
    .task_start  (task_start),
    .L_x         (L_x),
    .L_x_valid   (L_x_valid),
    .L_out       (L_out),
    .L_out_valid (L_out_valid),
    .L_done      (L_done),
    .L_err       (L_err),
    .busy        (busy)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           cyc_start = 0;
  int           done_cyc = 0;
  int           done_cnt = 0;
  logic         err_got = 1'b0;
  logic         busy_at_done = 1'b0;
  logic [K-1:0] q_got[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (L_out_valid) q_got.push_back(L_out);
    if (L_done) begin
      done_cnt++;
      if (done_cnt == 1) begin
        done_cyc     = cyc;
        err_got      = L_err;
        busy_at_done = busy;
      end
    end
  endtask

  task automatic load_n(input logic [15:0] nv);
    for (int w = 0; w < N; w++) begin
      n_word  = nv[8*w +: 8];
      n_valid = 1'b1;
      tick();
    end
    n_valid = 1'b0;
  endtask

  task automatic start_load(input logic [31:0] x, input int gap, input bit with_n,
                            input logic [7:0] nw);
    q_got.delete();
    done_cnt   = 0;
    task_start = 1'b1;
    n_valid    = with_n;
    n_word     = nw;
    cyc_start  = cyc;
    tick();
    task_start = 1'b0;
    n_valid    = 1'b0;
    for (int w = 0; w < 2*N; w++) begin
      L_x       = x[8*w +: 8];
      L_x_valid = 1'b1;
      tick();
      L_x_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_done(input bit poke);
    for (int b = 0; b < 200 && done_cnt == 0; b++) begin
      if (poke && (cyc - cyc_start) == 12) begin
        task_start = 1'b1;
        n_valid    = 1'b1;
        n_word     = 8'h55;
      end else begin
        task_start = 1'b0;
        n_valid    = 1'b0;
      end
      tick();
    end
    task_start = 1'b0;
    n_valid    = 1'b0;
  endtask

  task automatic job(input string tag, input logic [31:0] x, input int gap, input bit poke,
                     input bit with_n, input logic [7:0] nw, input logic [15:0] exp_q,
                     input logic exp_err, input bit chk_lat);
    start_load(x, gap, with_n, nw);
    wait_done(poke);
    chk({tag, ".done"}, done_cnt, 1);
    chk({tag, ".nq"}, q_got.size(), 2);
    if (q_got.size() == 2) begin
      chk({tag, ".q0"}, {24'h0, q_got[0]}, {24'h0, exp_q[7:0]});
      chk({tag, ".q1"}, {24'h0, q_got[1]}, {24'h0, exp_q[15:8]});
    end
    chk({tag, ".err"}, {31'h0, err_got}, {31'h0, exp_err});
    chk({tag, ".busy_at_done"}, {31'h0, busy_at_done}, 32'h1);
    if (chk_lat) chk({tag, ".latency"}, done_cyc - cyc_start, LAT);
    tick();
    chk({tag, ".busy_after"}, {31'h0, busy}, 32'h0);
    chk({tag, ".single_done"}, done_cnt, 1);
    $display("job %s x=%08h q=%0d words err=%0b cycles=%0d", tag, x, q_got.size(),
             err_got, done_cyc - cyc_start);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".out_valid"}, {31'h0, L_out_valid}, 32'h0);
    chk({tag, ".out"}, {24'h0, L_out}, 32'h0);
    chk({tag, ".done"}, {31'h0, L_done}, 32'h0);
    chk({tag, ".err"}, {31'h0, L_err}, 32'h0);
    chk({tag, ".busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    repeat (3) tick();
    chk_quiet("reset");
    rst_n = 1'b1;
    tick();

    load_n(16'h0101);
    n_inv0 = 8'h01;
    job("exact",   32'h0000_0506, 0, 1'b0, 1'b0, 8'h00, 16'h0005, 1'b0, 1'b1);
    job("maxq",    32'h0001_0101, 0, 1'b0, 1'b0, 8'h00, 16'h0100, 1'b0, 1'b1);
    job("inexact", 32'h0000_0508, 0, 1'b0, 1'b0, 8'h00, 16'hFE07, 1'b1, 1'b1);
    job("x_one",   32'h0000_0001, 0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    job("x_zero",  32'h0000_0000, 0, 1'b0, 1'b0, 8'h00, 16'h00FF, 1'b1, 1'b1);
    job("gapped",  32'h0000_0506, 2, 1'b0, 1'b0, 8'h00, 16'h0005, 1'b0, 1'b0);
    job("poke",    32'h0000_0506, 0, 1'b1, 1'b0, 8'h00, 16'h0005, 1'b0, 1'b1);
    job("after_poke", 32'h0001_0101, 0, 1'b0, 1'b0, 8'h00, 16'h0100, 1'b0, 1'b1);

    // Abort in MULSUB(0), then confirm silence and a clean restart.
    start_load(32'h0000_0506, 0, 1'b0, 8'h00);
    while ((cyc - cyc_start) < 10) tick();
    q_got.delete();
    done_cnt = 0;
    rst_n = 1'b0;
    tick();
    chk_quiet("abort");
    rst_n = 1'b1;
    repeat (40) tick();
    chk("abort.no_out", q_got.size(), 0);
    chk("abort.no_done", done_cnt, 0);
    $display("abort reset applied mid-MULSUB, pulses after=%0d", q_got.size() + done_cnt);
    job("restart", 32'h0000_0506, 0, 1'b0, 1'b0, 8'h00, 16'h0005, 1'b0, 1'b1);

    // n word 1 written in the same cycle as task_start.
    n_word  = 8'h03;
    n_valid = 1'b1;
    tick();
    n_valid = 1'b0;
    n_inv0  = 8'hAB;
    job("inv_ab",  32'h0000_012D, 0, 1'b0, 1'b1, 8'h00, 16'h0064, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
